// File: rtl/bp_pkg.sv
// bp_pkg: shared defaults and saturating counter step for the branch predictor
package bp_pkg;
  localparam int IDX_W_DEF = 6;
  localparam int CTR_W_DEF = 2;
  localparam int HIST_W_DEF = 6;
  localparam bit GSHARE_DEF = 1'b1;
  function automatic logic [3:0] sat_step(input logic [3:0] value, input logic inc, input logic dec, input int w);
    logic [3:0] top;
    top = 4'((5'd1 << w) - 5'd1);
    return inc && value != top ? value + 4'd1 : dec && value != 4'd0 ? value - 4'd1 : value;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: next value of a saturating up/down counter
module sat_counter import bp_pkg::*; #(
  parameter int W = CTR_W_DEF
) (
  input  logic [W-1:0] value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] next
);
  assign next = W'(sat_step(4'(value), inc, dec, W));
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: PC-xor-global-history indexed table of saturating counters
module gshare_predictor import bp_pkg::*; #(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CTR_W = CTR_W_DEF,
  parameter int HIST_W = HIST_W_DEF,
  parameter logic [CTR_W-1:0] CTR_INIT = '1,
  parameter bit GSHARE = GSHARE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  output logic [15:0]      mispred_cnt
);
  localparam int GH_W = HIST_W > 0 ? HIST_W : 1;
  logic [CTR_W-1:0] ctr [2**IDX_W];
  logic [GH_W-1:0] ghist;
  logic [IDX_W-1:0] hist_idx;
  logic [IDX_W-1:0] req_idx;
  logic [CTR_W-1:0] upd_next;
  logic [CTR_W-1:0] rd;
  logic unused_pc;
  assign unused_pc = ^{req_pc[31:IDX_W+2], req_pc[1:0]};
  assign hist_idx = GSHARE && HIST_W > 0 ? IDX_W'(ghist) : '0;
  assign req_idx = req_pc[IDX_W+1:2] ^ hist_idx;
  // same-index update is forwarded so the prediction sees the trained value
  assign rd = upd_valid && upd_idx == req_idx ? upd_next : ctr[req_idx];
  sat_counter #(.W(CTR_W)) u_sat (
    .value(ctr[upd_idx]),
    .inc(upd_taken),
    .dec(!upd_taken),
    .next(upd_next)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= CTR_INIT;
      ghist <= '0;
      mispred_cnt <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_idx <= '0;
    end else begin
      pred_valid <= req_valid;
      if (req_valid) begin
        pred_taken <= rd[CTR_W-1];
        pred_idx <= req_idx;
      end
      if (upd_valid) begin
        ctr[upd_idx] <= upd_next;
        ghist <= GH_W'({ghist, upd_taken});
      end
      if (upd_valid && upd_mispred && mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed table, saturation and random checks for gshare and pc-only variants
module tb_gshare_predictor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req_valid, upd_valid, upd_taken, upd_mispred;
  logic [31:0] req_pc;
  logic [5:0] upd_idx;
  logic pv1, pt1, pv0, pt0;
  logic [5:0] idx1, idx0;
  logic [15:0] cnt1, cnt0;
  gshare_predictor u_g1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(pv1), .pred_taken(pt1), .pred_idx(idx1),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .mispred_cnt(cnt1)
  );
  gshare_predictor #(.GSHARE(0)) u_g0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pc(req_pc),
    .pred_valid(pv0), .pred_taken(pt0), .pred_idx(idx0),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_mispred(upd_mispred), .mispred_cnt(cnt0)
  );
  typedef struct {
    logic r, rq;
    logic [31:0] pc;
    logic u;
    logic [5:0] ui;
    logic t, m;
    logic chk, e_pv, e_pt0, e_pt1;
    logic [5:0] e_idx1;
  } vec_t;
  vec_t vt [26];
  int n_cmp = 0;
  int n_bad = 0;
  int m_ctr [2][64];
  int m_gh, m_cnt, m_pv;
  int m_pt [2];
  int m_idx [2];
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // Reference: apply the training first, then read; this gives write-first for a shared index.
  task automatic ref_model();
    int ri [2];
    int c;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 64; i++) m_ctr[k][i] = 3;
        m_pt[k] = 0;
        m_idx[k] = 0;
      end
      m_gh = 0;
      m_cnt = 0;
      m_pv = 0;
    end else begin
      ri[0] = int'((req_pc >> 2) & 32'h3F);
      ri[1] = ri[0] ^ m_gh;
      for (int k = 0; k < 2; k++) begin
        if (upd_valid) begin
          c = m_ctr[k][upd_idx];
          m_ctr[k][upd_idx] = upd_taken ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
        end
        if (req_valid) begin
          m_pt[k] = m_ctr[k][ri[k]] >= 2 ? 1 : 0;
          m_idx[k] = ri[k];
        end
      end
      m_pv = req_valid ? 1 : 0;
      if (upd_valid) m_gh = ((m_gh << 1) | int'(upd_taken)) & 63;
      if (upd_valid && upd_mispred && m_cnt < 65535) m_cnt++;
    end
  endtask
  task automatic step(input logic r, input logic rq, input logic [31:0] pc, input logic u,
                      input logic [5:0] ui, input logic t, input logic m);
    rst_n = r;
    req_valid = rq;
    req_pc = pc;
    upd_valid = u;
    upd_idx = ui;
    upd_taken = t;
    upd_mispred = m;
    ref_model();
    @(posedge clk);
    #1;
    check("g1 pred_valid", int'(pv1), m_pv);
    check("g0 pred_valid", int'(pv0), m_pv);
    check("g1 pred_taken", int'(pt1), m_pt[1]);
    check("g0 pred_taken", int'(pt0), m_pt[0]);
    check("g1 pred_idx", int'(idx1), m_idx[1]);
    check("g0 pred_idx", int'(idx0), m_idx[0]);
    check("g1 mispred_cnt", int'(cnt1), m_cnt);
    check("g0 mispred_cnt", int'(cnt0), m_cnt);
  endtask
  initial begin
    vt = '{
      '{1'b0, 1'b0, 32'h0,   1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b1, 32'h100, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b1, 32'h14,  1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd5},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b1, 32'h14,  1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd6},
      '{1'b0, 1'b0, 32'h0,   1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b1, 32'h0,   1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5},
      '{1'b1, 1'b0, 32'h0,   1'b1, 6'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b1, 32'hC,   1'b1, 6'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd9},
      '{1'b1, 1'b1, 32'hC,   1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd23},
      '{1'b1, 1'b1, 32'h100, 1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd20},
      '{1'b1, 1'b1, 32'h1C,  1'b1, 6'd7,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd47},
      '{1'b1, 1'b1, 32'h100, 1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd16},
      '{1'b0, 1'b1, 32'h100, 1'b1, 6'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0},
      '{1'b1, 1'b1, 32'h0,   1'b0, 6'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0}
    };
    for (int i = 0; i < 26; i++) begin
      step(vt[i].r, vt[i].rq, vt[i].pc, vt[i].u, vt[i].ui, vt[i].t, vt[i].m);
      if (vt[i].chk) begin
        check($sformatf("vec%0d pv", i), int'(pv1), int'(vt[i].e_pv));
        check($sformatf("vec%0d pv0", i), int'(pv0), int'(vt[i].e_pv));
        check($sformatf("vec%0d pt0", i), int'(pt0), int'(vt[i].e_pt0));
        check($sformatf("vec%0d pt1", i), int'(pt1), int'(vt[i].e_pt1));
        check($sformatf("vec%0d idx1", i), int'(idx1), int'(vt[i].e_idx1));
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 32'h10002; i++)
      step(1'b1, 1'b0, 32'h0, 1'b1, 6'($urandom_range(63)), 1'($urandom_range(1)), 1'b1);
    check("sat cnt g1", int'(cnt1), 16'hFFFF);
    check("sat cnt g0", int'(cnt0), 16'hFFFF);
    step(1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("cnt after reset", int'(cnt1), 0);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1, 32'(i << 2), 1'b0, 6'd0, 1'b0, 1'b0);
      check($sformatf("post-reset taken g0 idx%0d", i), int'(pt0), 1);
      check($sformatf("post-reset taken g1 idx%0d", i), int'(pt1), 1);
    end
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      logic [5:0] ui;
      pc = $urandom;
      ui = $urandom_range(1) ? 6'((pc >> 2) ^ 32'(m_gh)) : 6'($urandom_range(63));
      step($urandom_range(63) != 0, 1'($urandom_range(1)), pc, 1'($urandom_range(1)), ui,
           1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
